// File: rtl/quad_encoder_counter_if.sv
// Signal bundle between the encoder front end and its consumers (speed/PID loop, position readers).
// speed_valid is a one-cycle strobe with no back-pressure; speed_count/speed_sat hold until the next tick.
interface quad_encoder_counter_if #(
  parameter int CNT_W = 16,
  parameter int POS_W = 32
);
  logic                    enable;
  logic [1:0]              mode;
  logic                    invert_dir;
  logic                    ch_a;
  logic                    ch_b;
  logic                    tick;
  logic                    clr_pos;
  logic                    err_clr;
  logic signed [CNT_W-1:0] speed_count;
  logic                    speed_valid;
  logic                    speed_sat;
  logic signed [POS_W-1:0] position;
  logic                    dir;
  logic                    err_sticky;
  logic                    dbg_primed;

  modport master (
    output enable, mode, invert_dir, ch_a, ch_b, tick, clr_pos, err_clr,
    input  speed_count, speed_valid, speed_sat, position, dir, err_sticky, dbg_primed
  );

  modport slave (
    input  enable, mode, invert_dir, ch_a, ch_b, tick, clr_pos, err_clr,
    output speed_count, speed_valid, speed_sat, position, dir, err_sticky, dbg_primed
  );
endinterface

// File: rtl/quad_encoder_counter.sv
// Quadrature encoder front end: synchroniser, per-channel glitch filter, x1/x2/x4 decode,
// saturating windowed speed count, wrapping position, direction and sticky error.
module quad_encoder_counter #(
  parameter int CNT_W       = 16,
  parameter int POS_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  quad_encoder_counter_if.slave  bus
);

  typedef enum logic {
    ST_UNPRIMED = 1'b0,
    ST_TRACK    = 1'b1
  } prime_state_t;

  localparam int WARM = SYNC_STAGES + FILT_LEN;
  localparam int WW   = $clog2(WARM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic [FILT_LEN-1:0]    hist_a, hist_b;
  logic                   filt_a, filt_b, vld_a, vld_b;
  logic [WW-1:0]          warm_cnt;
  logic                   warm_done, accept_a, accept_b;

  prime_state_t state, state_next;
  logic         prime_load;
  logic [1:0]   prev_idx, cur_idx, diff;
  logic         tracking, move_fwd, move_rev, illegal, gate, count_step, step_neg;

  logic [CNT_W-1:0] win, win_next, speed_count_q;
  logic             sat, sat_hit, speed_valid_q, speed_sat_q;
  logic [POS_W-1:0] pos;
  logic             dir_q, err_q;

  // Hold off acceptance until the filter history contains only post-reset samples.
  assign warm_done = (warm_cnt == WW'(WARM));
  assign accept_a  = warm_done && ((&hist_a) || !(|hist_a)) && (!vld_a || (hist_a[0] != filt_a));
  assign accept_b  = warm_done && ((&hist_b) || !(|hist_b)) && (!vld_b || (hist_b[0] != filt_b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a   <= '0;
      sync_b   <= '0;
      hist_a   <= '0;
      hist_b   <= '0;
      filt_a   <= 1'b0;
      filt_b   <= 1'b0;
      vld_a    <= 1'b0;
      vld_b    <= 1'b0;
      warm_cnt <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], bus.ch_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], bus.ch_b};
      hist_a <= FILT_LEN'({hist_a, sync_a[SYNC_STAGES-1]});
      hist_b <= FILT_LEN'({hist_b, sync_b[SYNC_STAGES-1]});
      if (!warm_done) warm_cnt <= warm_cnt + WW'(1);
      if (accept_a) begin
        filt_a <= hist_a[0];
        vld_a  <= 1'b1;
      end
      if (accept_b) begin
        filt_b <= hist_b[0];
        vld_b  <= 1'b1;
      end
    end
  end

  // Gray position index: 00->0, 10->1, 11->2, 01->3, so forward is +1 mod 4.
  assign cur_idx  = {filt_b, filt_a ^ filt_b};
  assign diff     = cur_idx - prev_idx;
  assign tracking = (state == ST_TRACK);
  assign move_fwd = tracking && (diff == 2'd1);
  assign move_rev = tracking && (diff == 2'd3);
  assign illegal  = tracking && (diff == 2'd2);

  always_comb begin
    state_next = state;
    prime_load = 1'b0;
    case (state)
      ST_UNPRIMED: if (vld_a && vld_b) begin
        state_next = ST_TRACK;
        prime_load = 1'b1;
      end
      default: state_next = ST_TRACK;
    endcase
  end

  always_comb begin
    gate = 1'b1;
    if (!bus.mode[1]) begin
      if (bus.mode[0]) gate = (prev_idx[1] == cur_idx[1]);
      else             gate = !prev_idx[1] && !cur_idx[1];
    end
  end

  assign count_step = bus.enable && (move_fwd || move_rev) && gate;
  assign step_neg   = move_rev ^ bus.invert_dir;

  always_comb begin
    win_next = win;
    sat_hit  = 1'b0;
    if (count_step) begin
      if (!step_neg) begin
        if (win == CNT_MAX) sat_hit  = 1'b1;
        else                win_next = win + CNT_W'(1);
      end else begin
        if (win == CNT_MIN) sat_hit  = 1'b1;
        else                win_next = win - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_UNPRIMED;
      prev_idx      <= 2'd0;
      win           <= '0;
      sat           <= 1'b0;
      speed_count_q <= '0;
      speed_valid_q <= 1'b0;
      speed_sat_q   <= 1'b0;
      pos           <= '0;
      dir_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state <= state_next;
      if (prime_load || tracking) prev_idx <= cur_idx;
      if (bus.tick) begin
        speed_count_q <= win_next;
        speed_sat_q   <= sat | sat_hit;
        win           <= '0;
        sat           <= 1'b0;
      end else begin
        win <= win_next;
        sat <= sat | sat_hit;
      end
      speed_valid_q <= bus.tick;
      if (bus.clr_pos)     pos <= '0;
      else if (count_step) pos <= step_neg ? pos - POS_W'(1) : pos + POS_W'(1);
      if (count_step) dir_q <= step_neg;
      // Set has priority over clear so a coincident fault is never lost.
      if (illegal && bus.enable) err_q <= 1'b1;
      else if (bus.err_clr)      err_q <= 1'b0;
    end
  end

  assign bus.speed_count = speed_count_q;
  assign bus.speed_valid = speed_valid_q;
  assign bus.speed_sat   = speed_sat_q;
  assign bus.position    = pos;
  assign bus.dir         = dir_q;
  assign bus.err_sticky  = err_q;
  assign bus.dbg_primed  = tracking;

endmodule
